// File: rtl/mem_stage_async_load.sv
// mem_stage_async_load: MEM pipeline stage for a split-transaction data SRAM.
// Holds one instruction between EX and WB, stalls a load until its response
// arrives, buffers the response under WB back-pressure, aligns/extends load
// data and silently drops responses that belong to flushed loads.
//
// Optional feature macro: MEM_RDATA_BYPASS_EN
//   defined   - an owned response can complete the load in the same cycle
//               (combinational rdata -> wdata/forwarding path)
//   undefined - every owned response is written to the buffer first; the load
//               leaves at least one cycle after data_ok
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   ex_to_mem_*                      instruction fields from EX (valid, payload,
//                                    rf_we, rf_waddr, alu_result, ld_op, req_issued)
//   mem_allowin                      MEM accepts EX this cycle
//   ex_cancel_inflight               EX killed an instruction whose request was accepted
//   mem_flush                        kill the instruction held in MEM
//   data_sram_data_ok/rdata          SRAM response
//   wb_allowin                       WB accepts
//   mem_to_wb_*                      instruction handed to WB (valid, payload, rf_we,
//                                    rf_waddr, wdata)
//   mem_fwd_we, mem_fwd_blocked      register-file forwarding bundle
//   mem_idle                         no instruction held and no orphan outstanding
module mem_stage_async_load #(
    parameter int unsigned PAYLOAD_W = 70,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ex_to_mem_valid,
    output logic                 mem_allowin,
    input  logic [PAYLOAD_W-1:0] ex_to_mem_payload,
    input  logic                 ex_to_mem_rf_we,
    input  logic [4:0]           ex_to_mem_rf_waddr,
    input  logic [31:0]          ex_to_mem_alu_result,
    input  logic [2:0]           ex_to_mem_ld_op,
    input  logic                 ex_to_mem_req_issued,
    input  logic                 ex_cancel_inflight,
    input  logic                 mem_flush,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 wb_allowin,
    output logic                 mem_to_wb_valid,
    output logic [PAYLOAD_W-1:0] mem_to_wb_payload,
    output logic                 mem_to_wb_rf_we,
    output logic [4:0]           mem_to_wb_rf_waddr,
    output logic [31:0]          mem_to_wb_wdata,
    output logic                 mem_fwd_we,
    output logic                 mem_fwd_blocked,
    output logic                 mem_idle
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    // One extra bit so the unsaturated +2 sum never wraps.
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;
    localparam logic [2:0] LD_W  = 3'b101;

    // Stage state
    logic                 mem_valid;
    logic                 buf_valid;
    logic [31:0]          buf_rdata;
    logic [CNT_W-1:0]     discard_cnt;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [31:0]          alu_result_q;
    logic [2:0]           ld_op_q;
    logic                 req_issued_q;

    // Combinational control
    logic             is_load;
    logic             cnt_zero;
    logic             rsp_own;
    logic             rsp_drop;
    logic             ready_go;
    logic             leave;
    logic             flush_orphan;
    logic             capture;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      load_raw;
    logic [31:0]      shifted;
    logic [31:0]      load_data;

    // Handshake and response ownership
    always_comb begin
        is_load         = (ld_op_q >= LD_B) && (ld_op_q <= LD_W) && req_issued_q;
        cnt_zero        = (discard_cnt == '0);
        rsp_own         = data_sram_data_ok & cnt_zero & mem_valid & is_load & ~buf_valid;
        rsp_drop        = data_sram_data_ok & ~cnt_zero;
`ifdef MEM_RDATA_BYPASS_EN
        ready_go        = ~is_load | buf_valid | rsp_own;
`else
        ready_go        = ~is_load | buf_valid;
`endif
        mem_allowin     = ~mem_valid | (ready_go & wb_allowin) | mem_flush;
        mem_to_wb_valid = mem_valid & ready_go & ~mem_flush;
        leave           = mem_to_wb_valid & wb_allowin;
        // A flushed load that has neither its response buffered nor arriving now
        // leaves a response in flight that must be discarded later.
        flush_orphan    = mem_flush & mem_valid & is_load & ~buf_valid & ~rsp_own;
        capture         = ex_to_mem_valid & mem_allowin & ~mem_flush;
    end

    // Discard counter next value, saturating at MAX_OUTST
    always_comb begin
        cnt_sum  = SUM_W'(discard_cnt) - SUM_W'(rsp_drop)
                 + SUM_W'(flush_orphan) + SUM_W'(ex_cancel_inflight);
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_sum > SUM_W'(MAX_OUTST)) begin
            cnt_next = CNT_W'(MAX_OUTST);
        end
    end

    // Load data selection and alignment/extension
    always_comb begin
`ifdef MEM_RDATA_BYPASS_EN
        load_raw = buf_valid ? buf_rdata : data_sram_rdata;
`else
        load_raw = buf_rdata;
`endif
        shifted   = load_raw >> {alu_result_q[1:0], 3'b000};
        load_data = shifted;
        case (ld_op_q)
            LD_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            LD_BU:   load_data = {24'h0, shifted[7:0]};
            LD_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            LD_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // WB and forwarding outputs
    always_comb begin
        mem_to_wb_payload  = payload_q;
        mem_to_wb_rf_we    = rf_we_q;
        mem_to_wb_rf_waddr = rf_waddr_q;
        mem_to_wb_wdata    = is_load ? load_data : alu_result_q;
        mem_fwd_we         = rf_we_q & mem_valid;
        mem_fwd_blocked    = mem_valid & is_load & ~ready_go;
        mem_idle           = ~mem_valid & cnt_zero;
    end

    // Stage valid and instruction fields
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid    <= 1'b0;
            payload_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            alu_result_q <= '0;
            ld_op_q      <= '0;
            req_issued_q <= 1'b0;
        end else begin
            if (mem_allowin) begin
                mem_valid <= ex_to_mem_valid & ~mem_flush;
            end
            if (capture) begin
                payload_q    <= ex_to_mem_payload;
                rf_we_q      <= ex_to_mem_rf_we;
                rf_waddr_q   <= ex_to_mem_rf_waddr;
                alu_result_q <= ex_to_mem_alu_result;
                ld_op_q      <= ex_to_mem_ld_op;
                req_issued_q <= ex_to_mem_req_issued;
            end
        end
    end

    // Response buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_rdata <= '0;
        end else begin
            if (leave || mem_flush) begin
                buf_valid <= 1'b0;
            end else if (rsp_own) begin
                buf_valid <= 1'b1;
            end
            if (rsp_own) begin
                buf_rdata <= data_sram_rdata;
            end
        end
    end

    // Orphaned-response counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= cnt_next;
        end
    end

`ifndef SYNTHESIS
    // More orphans than MAX_OUTST means the environment broke the protocol.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (cnt_sum <= SUM_W'(MAX_OUTST))
                else $error("mem_stage_async_load: discard counter overflow");
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_async_load.sv
// Testbench for mem_stage_async_load: directed scenarios followed by a
// randomized phase, all checked against a transaction-level model.
module tb_mem_stage_async_load;

    localparam int unsigned PAYLOAD_W = 70;
    localparam int unsigned MAX_OUTST = 2;
`ifdef MEM_RDATA_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 clk;
    logic                 resetn;
    logic                 ex_to_mem_valid;
    logic                 mem_allowin;
    logic [PAYLOAD_W-1:0] ex_to_mem_payload;
    logic                 ex_to_mem_rf_we;
    logic [4:0]           ex_to_mem_rf_waddr;
    logic [31:0]          ex_to_mem_alu_result;
    logic [2:0]           ex_to_mem_ld_op;
    logic                 ex_to_mem_req_issued;
    logic                 ex_cancel_inflight;
    logic                 mem_flush;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic                 wb_allowin;
    logic                 mem_to_wb_valid;
    logic [PAYLOAD_W-1:0] mem_to_wb_payload;
    logic                 mem_to_wb_rf_we;
    logic [4:0]           mem_to_wb_rf_waddr;
    logic [31:0]          mem_to_wb_wdata;
    logic                 mem_fwd_we;
    logic                 mem_fwd_blocked;
    logic                 mem_idle;

    mem_stage_async_load #(.PAYLOAD_W(PAYLOAD_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .ex_to_mem_valid      (ex_to_mem_valid),
        .mem_allowin          (mem_allowin),
        .ex_to_mem_payload    (ex_to_mem_payload),
        .ex_to_mem_rf_we      (ex_to_mem_rf_we),
        .ex_to_mem_rf_waddr   (ex_to_mem_rf_waddr),
        .ex_to_mem_alu_result (ex_to_mem_alu_result),
        .ex_to_mem_ld_op      (ex_to_mem_ld_op),
        .ex_to_mem_req_issued (ex_to_mem_req_issued),
        .ex_cancel_inflight   (ex_cancel_inflight),
        .mem_flush            (mem_flush),
        .data_sram_data_ok    (data_sram_data_ok),
        .data_sram_rdata      (data_sram_rdata),
        .wb_allowin           (wb_allowin),
        .mem_to_wb_valid      (mem_to_wb_valid),
        .mem_to_wb_payload    (mem_to_wb_payload),
        .mem_to_wb_rf_we      (mem_to_wb_rf_we),
        .mem_to_wb_rf_waddr   (mem_to_wb_rf_waddr),
        .mem_to_wb_wdata      (mem_to_wb_wdata),
        .mem_fwd_we           (mem_fwd_we),
        .mem_fwd_blocked      (mem_fwd_blocked),
        .mem_idle             (mem_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the instruction held in MEM, its response (if received) and the
    // number of responses still owed to killed loads.
    bit                   m_valid;
    logic [PAYLOAD_W-1:0] m_pay;
    bit                   m_we;
    logic [4:0]           m_waddr;
    logic [31:0]          m_alu;
    logic [2:0]           m_op;
    bit                   m_iss;
    bit                   m_have;
    logic [31:0]          m_data;
    int                   m_orph;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_load();
        return (m_op >= 3'd1) && (m_op <= 3'd5) && m_iss;
    endfunction

    // Load result from the byte offset and the access type, using arithmetic.
    function automatic logic [31:0] ref_align(input logic [2:0] op, input int unsigned off,
                                              input logic [31:0] data);
        int unsigned sh;
        int unsigned b;
        int unsigned h;
        sh = data / (32'd1 << (8 * off));
        b  = sh % 256;
        h  = sh % 65536;
        case (op)
            3'd1:    return (b >= 128) ? 32'(int'(b) - 256) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? 32'(int'(h) - 65536) : h;
            3'd4:    return h;
            default: return sh;
        endcase
    endfunction

    // Does a response arrive for the held load this cycle, and can it leave.
    function automatic void derive(output bit own, output bit done);
        own  = (data_sram_data_ok === 1'b1) && (m_orph == 0) && m_valid && m_is_load() && !m_have;
        done = !m_is_load() || m_have || (BYPASS && own);
    endfunction

    task automatic m_reset();
        m_valid = 0; m_have = 0; m_orph = 0; m_we = 0; m_iss = 0;
        m_op = '0; m_alu = '0; m_waddr = '0; m_pay = '0; m_data = '0;
    endtask

    // Compare all outputs against the model, away from the clock edge.
    task automatic settle();
        bit own, done, ld;
        logic [31:0] exp_wdata;
        @(negedge clk);
        derive(own, done);
        ld = m_is_load();
        chk("to_wb_valid", 128'(mem_to_wb_valid), 128'(m_valid && done && !mem_flush));
        chk("allowin", 128'(mem_allowin), 128'(!m_valid || (done && wb_allowin) || mem_flush));
        chk("fwd_we", 128'(mem_fwd_we), 128'(m_valid && m_we));
        chk("fwd_blocked", 128'(mem_fwd_blocked), 128'(m_valid && ld && !done));
        chk("idle", 128'(mem_idle), 128'(!m_valid && m_orph == 0));
        if (m_valid && done) begin
            exp_wdata = ld ? ref_align(m_op, int'(m_alu[1:0]), m_have ? m_data : data_sram_rdata) : m_alu;
            chk("wdata", 128'(mem_to_wb_wdata), 128'(exp_wdata));
            chk("payload", 128'(mem_to_wb_payload), 128'(m_pay));
            chk("rf_we", 128'(mem_to_wb_rf_we), 128'(m_we));
            chk("rf_waddr", 128'(mem_to_wb_rf_waddr), 128'(m_waddr));
        end
    endtask

    // Advance the model across the clock edge with the inputs held stable.
    task automatic tick();
        bit own, done, drop, orph_new, leave, departs, allow;
        @(posedge clk);
        derive(own, done);
        drop     = data_sram_data_ok && (m_orph > 0);
        orph_new = mem_flush && m_valid && m_is_load() && !m_have && !own;
        leave    = m_valid && done && !mem_flush && wb_allowin;
        departs  = leave || (m_valid && mem_flush);
        allow    = !m_valid || (done && wb_allowin) || mem_flush;
        m_orph   = m_orph - int'(drop) + int'(orph_new) + int'(ex_cancel_inflight);
        if (m_orph > int'(MAX_OUTST)) m_orph = int'(MAX_OUTST);
        if (own && !departs) begin
            m_have = 1;
            m_data = data_sram_rdata;
        end
        if (departs) m_have = 0;
        if (allow) begin
            if (ex_to_mem_valid && !mem_flush) begin
                m_valid = 1; m_have = 0;
                m_pay = ex_to_mem_payload; m_we = ex_to_mem_rf_we; m_waddr = ex_to_mem_rf_waddr;
                m_alu = ex_to_mem_alu_result; m_op = ex_to_mem_ld_op; m_iss = ex_to_mem_req_issued;
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_in();
        ex_to_mem_valid = 0; ex_to_mem_ld_op = '0; ex_to_mem_req_issued = 0;
        ex_cancel_inflight = 0; mem_flush = 0; data_sram_data_ok = 0; wb_allowin = 1;
    endtask

    task automatic ex_in(input logic [2:0] op, input logic [31:0] alu, input logic [4:0] rd,
                         input logic we, input logic iss);
        ex_to_mem_valid = 1; ex_to_mem_ld_op = op; ex_to_mem_alu_result = alu;
        ex_to_mem_rf_waddr = rd; ex_to_mem_rf_we = we; ex_to_mem_req_issued = iss;
        ex_to_mem_payload = PAYLOAD_W'({$urandom(), $urandom(), $urandom()});
    endtask

    // Drive one response and wait (bounded) for the load to reach WB.
    task automatic wait_load(input logic [31:0] rd, input logic [31:0] exp, input string tag);
        bit found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            idle_in();
            data_sram_data_ok = (i == 0);
            data_sram_rdata   = (i == 0) ? rd : ~rd;
            settle();
            if (mem_to_wb_valid === 1'b1) begin
                chk(tag, 128'(mem_to_wb_wdata), 128'(exp));
                found = 1;
            end
            tick();
        end
        chk({tag, "_reached_wb"}, 128'(found), 128'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_to_wb_valid"}, 128'(mem_to_wb_valid), 128'(0));
        chk({tag, "_allowin"}, 128'(mem_allowin), 128'(1));
        chk({tag, "_fwd_we"}, 128'(mem_fwd_we), 128'(0));
        chk({tag, "_fwd_blocked"}, 128'(mem_fwd_blocked), 128'(0));
        chk({tag, "_idle"}, 128'(mem_idle), 128'(1));
    endtask

    task automatic rand_in();
        bit own, done, drop, orph_new, own_pend;
        wb_allowin      = ($urandom_range(3) != 0);
        ex_to_mem_valid = ($urandom_range(99) < 60);
        ex_in(3'($urandom_range(7)), $urandom(), 5'($urandom_range(31)),
              1'($urandom_range(1)), ($urandom_range(4) != 0));
        ex_to_mem_valid = ($urandom_range(99) < 60);
        own_pend = m_valid && m_is_load() && !m_have;
        if (m_orph > 0 || own_pend) data_sram_data_ok = ($urandom_range(99) < 40);
        else                        data_sram_data_ok = ($urandom_range(99) < 3);
        data_sram_rdata    = $urandom();
        mem_flush          = ($urandom_range(99) < 8);
        ex_cancel_inflight = !ex_to_mem_valid && ($urandom_range(99) < 10);
        derive(own, done);
        drop     = data_sram_data_ok && (m_orph > 0);
        orph_new = mem_flush && m_valid && m_is_load() && !m_have && !own;
        if (m_orph - int'(drop) + int'(orph_new) + int'(ex_cancel_inflight) > int'(MAX_OUTST))
            ex_cancel_inflight = 0;
        if (m_orph - int'(drop) + int'(orph_new) > int'(MAX_OUTST))
            mem_flush = 0;
    endtask

    initial begin
        resetn = 0;
        idle_in();
        ex_to_mem_payload = '0; ex_to_mem_rf_we = 0; ex_to_mem_rf_waddr = '0;
        ex_to_mem_alu_result = '0; data_sram_rdata = '0;
        m_reset();
        #2;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1;

        // 1: ld.b from offset 3, response two cycles late
        ex_in(3'd1, 32'h0000_1003, 5'd3, 1, 1);
        cyc();
        idle_in();
        settle(); chk("t1_blocked0", 128'(mem_fwd_blocked), 128'(1)); tick();
        settle(); chk("t1_blocked1", 128'(mem_fwd_blocked), 128'(1)); tick();
        wait_load(32'h80FF_0000, 32'hFFFF_FF80, "t1_wdata");

        // 2: ld.hu from offset 2 with WB stalled for three cycles
        ex_in(3'd4, 32'h0000_2002, 5'd4, 1, 1);
        cyc();
        idle_in();
        wb_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h8001_1234;
        settle(); chk("t2_allowin_rsp", 128'(mem_allowin), 128'(0)); tick();
        for (int k = 0; k < 2; k++) begin
            idle_in(); wb_allowin = 0; data_sram_rdata = $urandom();
            settle();
            chk("t2_hold_valid", 128'(mem_to_wb_valid), 128'(1));
            chk("t2_hold_wdata", 128'(mem_to_wb_wdata), 128'(32'h0000_8001));
            tick();
        end
        idle_in();
        settle(); chk("t2_release_wdata", 128'(mem_to_wb_wdata), 128'(32'h0000_8001)); tick();
        settle(); chk("t2_gone", 128'(mem_to_wb_valid), 128'(0)); tick();

        // 3: flush a waiting ld.w; its response is discarded, the next load is served
        ex_in(3'd5, 32'h0000_3000, 5'd6, 1, 1);
        cyc();
        idle_in(); mem_flush = 1;
        settle(); chk("t3_flush_valid", 128'(mem_to_wb_valid), 128'(0)); tick();
        idle_in();
        settle(); chk("t3_cnt1", 128'(mem_idle), 128'(0)); tick();
        data_sram_data_ok = 1; data_sram_rdata = 32'h1111_1111;
        cyc();
        idle_in();
        settle(); chk("t3_cnt0", 128'(mem_idle), 128'(1)); tick();
        ex_in(3'd5, 32'h0000_3004, 5'd7, 1, 1);
        cyc();
        wait_load(32'hDEAD_BEEF, 32'hDEAD_BEEF, "t3_own");

        // 4: flush of a waiting load together with a cancelled EX request
        ex_in(3'd5, 32'h0000_4000, 5'd8, 1, 1);
        cyc();
        idle_in(); mem_flush = 1; ex_cancel_inflight = 1;
        cyc();
        idle_in(); data_sram_data_ok = 1; data_sram_rdata = $urandom();
        settle(); chk("t4_cnt2", 128'(mem_idle), 128'(0)); tick();
        settle(); chk("t4_cnt1", 128'(mem_idle), 128'(0)); tick();
        idle_in();
        settle(); chk("t4_idle", 128'(mem_idle), 128'(1)); tick();

        // 5: flush and own response in the same cycle
        ex_in(3'd5, 32'h0000_5000, 5'd9, 1, 1);
        cyc();
        idle_in(); mem_flush = 1; data_sram_data_ok = 1; data_sram_rdata = $urandom();
        settle(); chk("t5_valid", 128'(mem_to_wb_valid), 128'(0)); tick();
        idle_in();
        settle(); chk("t5_cnt0", 128'(mem_idle), 128'(1)); tick();

        // 6: add then reset in the middle of a load wait
        ex_in(3'd0, 32'h0000_0042, 5'd5, 1, 0);
        cyc();
        ex_in(3'd5, 32'h0000_6000, 5'd10, 1, 1);
        settle();
        chk("t6_add_wdata", 128'(mem_to_wb_wdata), 128'(32'h42));
        chk("t6_add_waddr", 128'(mem_to_wb_rf_waddr), 128'(5));
        tick();
        idle_in();
        cyc();
        resetn = 0;
        #1;
        m_reset();
        chk_reset_outputs("t6_reset");
        @(posedge clk); #1;
        resetn = 1;
        data_sram_data_ok = 1; data_sram_rdata = $urandom();
        settle(); chk("t6_late_rsp", 128'(mem_idle), 128'(1)); tick();
        idle_in();
        cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
